// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared constants and types for the fifo write-port arbiter family.
//   DEF_DATA_W    : default word width (matches the team 8-bit fifo)
//   DEF_NUM_REQ   : default producer count
//   DEF_MAX_BURST : default words per grant before forced re-arbitration
//   STAT_W        : width of each statistics counter
//   arb_state_e   : arbiter control state (IDLE / BURST)
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 4;
  localparam int STAT_W        = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker. Scans the request vector starting
// one position after last_id and wrapping modulo NUM_REQ; the first set bit
// wins. Generic so other arbiters can reuse it.
// Ports:
//   req     in  NUM_REQ  request vector
//   last_id in  ID_W     index granted most recently (lowest priority now)
//   found   out 1        at least one request is set
//   winner  out ID_W     index of the winning request (0 when !found)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_id,
  output logic               found,
  output logic [ID_W-1:0]    winner
);

  // Walk from the farthest candidate back to the nearest so the nearest set
  // bit after last_id is the one left standing.
  always_comb begin
    logic [ID_W-1:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(last_id) + k) % NUM_REQ);
      if (req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing the single write port of the 8-bit fifo among
// NUM_REQ producers. A winner owns the port for a burst of up to MAX_BURST
// words; the fifo full flag is the only back-pressure. Each grant costs one
// arbitration bubble cycle (IDLE) before its first write.
//
// Parameters: NUM_REQ (2..8), DATA_W, MAX_BURST (1..16)
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   req          in   NUM_REQ         per-producer word valid
//   req_data     in   NUM_REQ*DATA_W  producer words, slice i = [i*DATA_W +: DATA_W]
//   ack          out  NUM_REQ         one-hot consume pulse
//   fifo_full    in   fifo full flag
//   fifo_wr_en   out  fifo write strobe
//   fifo_data_in out  DATA_W          fifo write data (0 when not writing)
//   grant_valid  out  a burst owner is held
//   grant_id     out  current or last owner index
// Optional (macro FIFO_WR_ARB_STATS_EN):
//   stat_words   out  NUM_REQ*16  per-requester saturating acked-word count
//   stat_stall   out  16          saturating count of full-stalled BURST cycles
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         ack,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [DATA_W-1:0]          fifo_data_in,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]  stat_words,
  output logic [STAT_W-1:0]          stat_stall
`endif
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [ID_W-1:0]  last_id_q, last_id_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic             pick_found;
  logic [ID_W-1:0]  pick_id;
  logic             owner_req;
  logic             wr_ok;
  logic             burst_last;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req     (req),
    .last_id (last_id_q),
    .found   (pick_found),
    .winner  (pick_id)
  );

  assign owner_req  = req[grant_id_q];
  assign burst_last = (burst_cnt_q == CNT_W'(MAX_BURST - 1));
  // rst gates the write so a reset landing mid-burst consumes nothing.
  assign wr_ok      = (state_q == BURST) && owner_req && !fifo_full && !rst;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
      last_id_q   <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
      last_id_q   <= last_id_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    last_id_d   = last_id_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = BURST;
          grant_id_d  = pick_id;
          burst_cnt_d = '0;
        end
      end
      BURST: begin
        if (!owner_req) begin
          // Owner withdrew: hand the port back and demote it in priority.
          state_d   = IDLE;
          last_id_d = grant_id_q;
        end else if (!fifo_full) begin
          if (burst_last) begin
            state_d     = IDLE;
            last_id_d   = grant_id_q;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
          end
        end
        // Full stall: hold everything, budget is not consumed.
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    fifo_wr_en   = 1'b0;
    fifo_data_in = '0;
    ack          = '0;
    grant_valid  = 1'b0;
    grant_id     = '0;
    if (!rst) begin
      grant_valid = (state_q == BURST);
      grant_id    = grant_id_q;
      if (wr_ok) begin
        fifo_wr_en      = 1'b1;
        fifo_data_in    = req_data[grant_id_q*DATA_W +: DATA_W];
        ack[grant_id_q] = 1'b1;
      end
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  logic [STAT_W-1:0] words_q [NUM_REQ];
  logic [STAT_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) words_q[i] <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ack[i]) words_q[i] <= sat_inc(words_q[i]);
      end
      if ((state_q == BURST) && owner_req && fifo_full) stall_q <= sat_inc(stall_q);
    end
  end

  always_comb begin
    stat_words = '0;
    stat_stall = '0;
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) stat_words[i*STAT_W +: STAT_W] = words_q[i];
      stat_stall = stall_q;
    end
  end
`endif

  a_ack_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(ack));
  a_wr_matches_ack : assert property (@(posedge clk) disable iff (rst) fifo_wr_en == (|ack));
  a_no_wr_when_full : assert property (@(posedge clk) disable iff (rst) fifo_full |-> !fifo_wr_en);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    ack;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_data_in;
  logic             grant_valid;
  logic [1:0]       grant_id;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [NR*16-1:0] stat_words;
  logic [15:0]      stat_stall;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_words   (stat_words),
    .stat_stall   (stat_stall)
`endif
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] pq [NR][$];
  logic [NR-1:0] ack_s;
  logic       rst_drv;
  logic       full_drv;
  int         tests;
  int         fails;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_exp(input int id, input logic [7:0] d);
    exp_t e;
    e.id   = 2'(id);
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (fifo_wr_en) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got data %0h ack %0h expected no write", fifo_data_in, ack);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_data", 32'(fifo_data_in), 32'(e.data));
        chk("wr_ack", 32'(ack), 32'(4'b0001 << e.id));
      end
    end else begin
      chk("no_wr_zero", 32'({ack, fifo_data_in}), 32'(0));
    end
  end

  // One clock: consume acked words, drive inputs after the edge, sample ack mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (ack_s[i] && pq[i].size() != 0) void'(pq[i].pop_front());
    end
    rst       = rst_drv;
    fifo_full = full_drv;
    for (int i = 0; i < NR; i++) begin
      req[i] = (pq[i].size() != 0);
      req_data[i*DW +: DW] = (pq[i].size() != 0) ? pq[i][0] : 8'h00;
    end
    @(negedge clk);
    ack_s = ack;
    #1;
  endtask

  task automatic do_reset();
    rst_drv = 1'b1;
    tick();
    rst_drv = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    rst_drv   = 1'b1;
    full_drv  = 1'b0;
    fifo_full = 1'b0;
    req       = '0;
    req_data  = '0;
    ack_s     = '0;

    // Reset: all outputs held at zero while rst is high
    tick();
    chk("rst_wr_en", 32'(fifo_wr_en), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_data", 32'(fifo_data_in), 0);
    chk("rst_gv", 32'(grant_valid), 0);
    chk("rst_gid", 32'(grant_id), 0);
    rst_drv = 1'b0;
    tick();
    chk("post_rst_gv", 32'(grant_valid), 0);
    chk("post_rst_gid", 32'(grant_id), 0);

    // Single requester burst A0..A3
    for (int k = 0; k < 4; k++) begin
      pq[0].push_back(8'hA0 + 8'(k));
      push_exp(0, 8'hA0 + 8'(k));
    end
    tick();
    chk("s1_bubble_wr", 32'(fifo_wr_en), 0);
    chk("s1_bubble_gv", 32'(grant_valid), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("s1_gv", 32'(grant_valid), 1);
      chk("s1_gid", 32'(grant_id), 0);
      chk("s1_wr", 32'(fifo_wr_en), 1);
    end
    tick();
    chk("s1_end_gv", 32'(grant_valid), 0);

    // All four requesting: order 0,1,2,3,0, 25 cycles
    do_reset();
    for (int k = 0; k < 8; k++) pq[0].push_back(8'h00 + 8'(k));
    for (int i = 1; i < NR; i++)
      for (int k = 0; k < 4; k++) pq[i].push_back(8'((i << 4) | k));
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 4; k++) push_exp(i, 8'((i << 4) | k));
    for (int k = 4; k < 8; k++) push_exp(0, 8'(k));
    n = 0;
    do begin
      tick();
      n++;
    end while (exp_q.size() != 0 && n < 60);
    chk("s2_cycles", n, 25);

    // Requester 2 with full held 3 cycles mid-burst
    for (int k = 0; k < 4; k++) begin
      pq[2].push_back(8'hC0 + 8'(k));
      push_exp(2, 8'hC0 + 8'(k));
    end
    tick();
    chk("s3_bubble_gv", 32'(grant_valid), 0);
    tick();
    chk("s3_gid", 32'(grant_id), 2);
    chk("s3_wr0", 32'(fifo_wr_en), 1);
    tick();
    chk("s3_wr1", 32'(fifo_wr_en), 1);
    full_drv = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("s3_stall_wr", 32'(fifo_wr_en), 0);
      chk("s3_stall_ack", 32'(ack), 0);
      chk("s3_stall_gv", 32'(grant_valid), 1);
    end
    full_drv = 1'b0;
    tick();
    chk("s3_wr2", 32'(fifo_wr_en), 1);
    tick();
    chk("s3_wr3", 32'(fifo_wr_en), 1);
    tick();
    chk("s3_end_gv", 32'(grant_valid), 0);

    // Owner 1 withdraws after 2 acks, requester 3 pending
    do_reset();
    for (int k = 0; k < 4; k++) begin
      pq[1].push_back(8'hD0 + 8'(k));
      pq[3].push_back(8'hE0 + 8'(k));
    end
    push_exp(1, 8'hD0);
    push_exp(1, 8'hD1);
    for (int k = 0; k < 4; k++) push_exp(3, 8'hE0 + 8'(k));
    tick();
    tick();
    chk("s4_gid1", 32'(grant_id), 1);
    tick();
    chk("s4_wr_d1", 32'(fifo_wr_en), 1);
    pq[1].delete();
    tick();
    chk("s4_wd_wr", 32'(fifo_wr_en), 0);
    chk("s4_wd_gv", 32'(grant_valid), 1);
    tick();
    chk("s4_idle_gv", 32'(grant_valid), 0);
    tick();
    chk("s4_gid3", 32'(grant_id), 3);
    chk("s4_wr_e0", 32'(fifo_wr_en), 1);
    for (int k = 0; k < 3; k++) tick();
    tick();
    chk("s4_end_gv", 32'(grant_valid), 0);

    // Reset during a burst by requester 0 with requester 1 pending
    for (int k = 0; k < 6; k++) begin
      pq[0].push_back(8'hF0 + 8'(k));
      push_exp(0, 8'hF0 + 8'(k));
    end
    for (int k = 0; k < 4; k++) begin
      pq[1].push_back(8'hB0 + 8'(k));
      push_exp(1, 8'hB0 + 8'(k));
    end
    tick();
    tick();
    chk("s5_gid0", 32'(grant_id), 0);
    tick();
    chk("s5_wr_f1", 32'(fifo_wr_en), 1);
    rst_drv = 1'b1;
    tick();
    chk("s5_rst_wr", 32'(fifo_wr_en), 0);
    chk("s5_rst_ack", 32'(ack), 0);
    chk("s5_rst_gv", 32'(grant_valid), 0);
    rst_drv = 1'b0;
    tick();
    chk("s5_bubble_gv", 32'(grant_valid), 0);
    chk("s5_bubble_wr", 32'(fifo_wr_en), 0);
    tick();
    chk("s5_regrant_gid", 32'(grant_id), 0);
    chk("s5_regrant_wr", 32'(fifo_wr_en), 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (exp_q.size() != 0 && n < 30);
    chk("s5_tail_cycles", n, 8);

`ifdef FIFO_WR_ARB_STATS_EN
    // Statistics: 20 bursts round-robin, then a held full
    do_reset();
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 20; k++) pq[i].push_back(8'((i << 6) | k));
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < NR; i++)
        for (int k = 0; k < 4; k++) push_exp(i, 8'((i << 6) | (r * 4 + k)));
    n = 0;
    do begin
      tick();
      n++;
    end while (exp_q.size() != 0 && n < 150);
    chk("st_cycles", n, 100);
    tick();
    for (int i = 0; i < NR; i++) chk("st_words", 32'(stat_words[i*16 +: 16]), 20);
    chk("st_stall0", 32'(stat_stall), 0);
    full_drv = 1'b1;
    pq[2].push_back(8'h77);
    push_exp(2, 8'h77);
    tick();
    for (int k = 0; k < 5; k++) tick();
    full_drv = 1'b0;
    tick();
    chk("st_stall5", 32'(stat_stall), 5);
    chk("st_wr_after_full", 32'(fifo_wr_en), 1);
    tick();
`endif

    tick();
    chk("exp_q_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that lets NUM_REQ producers share the single write port of the team's 8-bit fifo.
- Grants one requester at a time for a bounded burst of up to MAX_BURST words.
- Drives fifo wr_en/data_in and returns a per-requester ack.
- Sits directly in front of the fifo instance; the fifo's full flag is the only back-pressure.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- DATA_W, 8, word width; must match the fifo data_in width.
- MAX_BURST, 4, max words accepted per grant before forced re-arbitration (1..16).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-producer request; bit i high = word on req_data slice i is valid.
- req_data  in  NUM_REQ*DATA_W  producer words; slice i = bits [i*DATA_W +: DATA_W].
- ack  out  NUM_REQ  one-hot pulse; the word on slice i is consumed this cycle.
- fifo_full  in  1  full flag from the fifo.
- fifo_wr_en  out  1  write strobe to the fifo.
- fifo_data_in  out  DATA_W  write data to the fifo.
- grant_valid  out  1  a burst owner is held (state BURST).
- grant_id  out  clog2(NUM_REQ)  current or last owner index.

Behaviour:
- Registered state: state {IDLE, BURST}, grant_id, burst_cnt, last_id.
- fifo_wr_en, fifo_data_in and ack are combinational from the registered state, req and fifo_full.
- Reset (rst=1 at posedge) sets:
  - state=IDLE, grant_id=0, burst_cnt=0, last_id=NUM_REQ-1, so req[0] has first priority.
  - All outputs are 0 while rst is high, including fifo_wr_en, ack and fifo_data_in.
  - A reset mid-burst aborts the burst; no write or ack occurs in that cycle.
- IDLE:
  - If req is nonzero, the winner is the first set bit scanning last_id+1, last_id+2, ... with modulo NUM_REQ wrap.
  - Next state is BURST with grant_id=winner and burst_cnt=0.
  - No write in the IDLE cycle: one-cycle arbitration bubble per burst.
- BURST (owner = grant_id, grant_valid=1):
  - Write condition: req[owner] && !fifo_full.
    - fifo_wr_en=1, fifo_data_in=req_data slice owner, ack[owner]=1, burst_cnt increments.
  - req[owner] && fifo_full: stall. No write, no ack, burst_cnt unchanged, stay in BURST. Full-stall cycles do not consume burst budget.
  - req[owner]==0: the owner has withdrawn. No write; go to IDLE; last_id=owner.
  - Write with burst_cnt==MAX_BURST-1: go to IDLE; last_id=owner.
  - Requests from non-owners are ignored in BURST; their ack stays 0.
- fifo_data_in is 0 whenever fifo_wr_en=0.
- Producer rules:
  - Hold req and data stable until ack.
  - May drop req before ack (withdraw).
  - After ack, may present the next word the following cycle.
- Fairness: after a burst by requester k, every other pending requester is granted before k is granted again.
- Throughput: MAX_BURST words per MAX_BURST+1 cycles per grant, absent full.
- Assertions:
  - ack is one-hot or zero.
  - fifo_wr_en == |ack.
  - fifo_wr_en never high while fifo_full.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- Defined:
  - Adds output stat_words (NUM_REQ*16): per-requester saturating count of acked words.
  - Adds output stat_stall (16): saturating count of BURST cycles with req[owner]&&fifo_full.
  - Both counters are cleared by rst.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Decomposition:
- Package fifo_arb_pkg:
  - Default constants DATA_W, NUM_REQ, MAX_BURST.
  - State enum IDLE/BURST.
  - STAT_W=16.
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: req vector, last_id.
  - Outputs: found flag, winner index.
  - Reusable by other arbiters in the codebase.

Test Plan:
- Reset then req=4'b0001, data0=8'hA0..A3 held per ack, fifo_full=0 -> IDLE bubble, then 4 consecutive writes A0,A1,A2,A3 with ack[0]; back to IDLE after the 4th.
- req=4'b1111 continuously, fifo_full=0 -> grant order 0,1,2,3,0; each burst is 4 writes plus 1 bubble; no requester is granted twice before the others.
- req[2] owner, fifo_full=1 for 3 cycles mid-burst -> fifo_wr_en=0 and ack=0 for those 3 cycles; burst still delivers 4 words total after full drops.
- Owner req[1] drops after 2 acks while req[3] pending -> IDLE next cycle; req[3] granted; last_id=1.
- rst pulsed during BURST with req[0] high -> no write in the reset cycle; after release, arbitration restarts from req[0] priority.
- FIFO_WR_ARB_STATS_EN defined, run scenario 2 for 20 bursts -> stat_words=20 per requester; stat_stall=0; then a held full increments stat_stall by 1 per cycle.
